// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, FSM state type and helpers
package kyber_pkg;

  localparam int Q     = 3329;
  localparam int N     = 256;
  localparam int DW    = 64;
  localparam int CW    = 12;
  localparam int BUF_W = 88;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic l_legal(input logic [3:0] l);
    case (l)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] lane_mask(input logic [3:0] l);
    return CW'((13'd1 << l) - 13'd1);
  endfunction

  // Stream words carry byte 0 in the top lane; coefficients are packed LSB first.
  function automatic logic [DW-1:0] byte_reverse(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    for (int b = 0; b < DW / 8; b++) begin
      r[8*b +: 8] = w[DW-1-8*b -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_decode_if.sv
// rtl/byte_decode_if.sv - byte-stream input and coefficient-pair output handshakes
interface byte_decode_if;
  import kyber_pkg::*;

  logic [DW-1:0]   i_bytes;
  logic            i_bytes_valid;
  logic            o_bytes_ready;
  logic [2*CW-1:0] o_coeffs;
  logic            o_coeffs_valid;
  logic            i_coeffs_ready;

  modport slave (
    input  i_bytes, i_bytes_valid, i_coeffs_ready,
    output o_bytes_ready, o_coeffs, o_coeffs_valid
  );

  modport master (
    output i_bytes, i_bytes_valid, i_coeffs_ready,
    input  o_bytes_ready, o_coeffs, o_coeffs_valid
  );

endinterface

// File: rtl/mod_q_csub.sv
// rtl/mod_q_csub.sv - 12-bit conditional subtract of Q with a ge flag
module mod_q_csub
  import kyber_pkg::*;
(
  input  logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          ge
);

  localparam logic [CW-1:0] QV = CW'(Q);

  assign ge = (x >= QV);
  assign y  = ge ? (x - QV) : x;

endmodule

// File: rtl/byte_decode.sv
// rtl/byte_decode.sv - Kyber ByteDecode_l: 64-bit byte words in, coefficient pairs out
module byte_decode
  import kyber_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_l,
  byte_decode_if.slave     bus,
  output logic             o_done,
  output logic             o_mod_err
);

  state_t           state_q, state_d;
  logic [3:0]       l_q;
  logic [BUF_W-1:0] buf_q;
  logic [6:0]       cnt_q;
  logic [5:0]       words_q;
  logic [6:0]       pairs_q;
  logic             mod_err_q;

  logic             start_ok;
  logic             in_run;
  logic [6:0]       two_l;
  logic             bytes_ready;
  logic             coeffs_valid;
  logic             accept;
  logic             consume;

  logic [CW-1:0]    mask;
  logic [CW-1:0]    raw0, raw1;
  logic [CW-1:0]    red0, red1;
  logic             ge0, ge1;
  logic [CW-1:0]    lane0, lane1;

  logic [BUF_W-1:0] buf_shift;
  logic [6:0]       app_pos;
  logic [BUF_W-1:0] buf_d;
  logic [6:0]       cnt_d;

  assign in_run = (state_q == RUN);
  assign two_l  = {2'b00, l_q, 1'b0};

  // At most 24 bits may be pending so a full word always fits in the 88-bit buffer.
  assign bytes_ready  = in_run && (cnt_q <= 7'd24) && (words_q < {l_q, 2'b00});
  assign coeffs_valid = in_run && (cnt_q >= two_l);
  assign accept       = bus.i_bytes_valid && bytes_ready;
  assign consume      = coeffs_valid && bus.i_coeffs_ready;

  assign mask = lane_mask(l_q);
  assign raw0 = buf_q[CW-1:0] & mask;
  assign raw1 = buf_q[{3'b000, l_q} +: CW] & mask;

  mod_q_csub u_csub0 (.x(raw0), .y(red0), .ge(ge0));
  mod_q_csub u_csub1 (.x(raw1), .y(red1), .ge(ge1));

  assign lane0 = (l_q == 4'd12) ? red0 : raw0;
  assign lane1 = (l_q == 4'd12) ? red1 : raw1;

  assign bus.o_bytes_ready  = bytes_ready;
  assign bus.o_coeffs_valid = coeffs_valid;
  assign bus.o_coeffs       = coeffs_valid ? {lane0, lane1} : '0;
  assign o_mod_err          = mod_err_q;

  // Retire the outgoing pair first, then append the new word just above what remains.
  always_comb begin
    buf_shift = consume ? (buf_q >> two_l) : buf_q;
    app_pos   = consume ? (cnt_q - two_l) : cnt_q;
    buf_d     = buf_shift;
    cnt_d     = app_pos;
    if (accept) begin
      buf_d = buf_shift | ({{(BUF_W-DW){1'b0}}, byte_reverse(bus.i_bytes)} << app_pos);
      cnt_d = app_pos + 7'd64;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    o_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && l_legal(i_l)) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (consume && (pairs_q == 7'd127)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      l_q       <= 4'd0;
      buf_q     <= '0;
      cnt_q     <= 7'd0;
      words_q   <= 6'd0;
      pairs_q   <= 7'd0;
      mod_err_q <= 1'b0;
    end else if (start_ok) begin
      l_q       <= i_l;
      buf_q     <= '0;
      cnt_q     <= 7'd0;
      words_q   <= 6'd0;
      pairs_q   <= 7'd0;
      mod_err_q <= 1'b0;
    end else if (in_run) begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      if (accept) begin
        words_q <= words_q + 6'd1;
      end
      if (consume) begin
        pairs_q <= pairs_q + 7'd1;
        if ((l_q == 4'd12) && (ge0 || ge1)) begin
          mod_err_q <= 1'b1;
        end
      end
    end
  end

endmodule
